// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit instruction encoder and decoder.
package cpu_isa_pkg;

  // Opcode field values [15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_LDR = 3'b011;
  localparam logic [2:0] OPC_STR = 3'b100;

  // Op / ALUop field values [12:11]
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b00;

  // Least-significant bit of each field in the instruction word
  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;

  // Field-level encode request
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic [1:0] shift;
    logic [7:0] imm;
  } enc_req_t;

  // Encode result: word is only meaningful when legal is set
  typedef struct packed {
    logic        legal;
    logic [15:0] word;
  } enc_res_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
  assign level   = level_q;

  // Next occupancy: push and pop together leave it unchanged
  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage write; contents need no reset since level gates the read
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally modulo DEPTH (power of two)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs field-level requests into 16-bit ISA words, queues them, and counts illegal requests.
module instr_encoder
  import cpu_isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_opcode,
  input  logic [1:0]              in_op,
  input  logic [2:0]              in_rn,
  input  logic [2:0]              in_rd,
  input  logic [2:0]              in_rm,
  input  logic [1:0]              in_shift,
  input  logic [7:0]              in_imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_instr,
  output logic                    err,
  output logic [ERRW-1:0]         err_count,
  output logic [$clog2(DEPTH):0]  level
);

  // Encode one request; fields not used by the format stay zero.
  function automatic enc_res_t encode(input enc_req_t r);
    enc_res_t res;
    res.legal = 1'b0;
    res.word  = '0;
    res.word[OPC_LSB +: 3] = r.opcode;
    res.word[OP_LSB  +: 2] = r.op;
    case (r.opcode)
      OPC_MOV: begin
        if (r.op == OP_MOVI) begin
          res.legal               = 1'b1;
          res.word[RN_LSB +: 3]   = r.rn;
          res.word[7:0]           = r.imm;
        end else if (r.op == OP_MOVR) begin
          res.legal               = 1'b1;
          res.word[RD_LSB +: 3]   = r.rd;
          res.word[SH_LSB +: 2]   = r.shift;
          res.word[RM_LSB +: 3]   = r.rm;
        end
      end
      OPC_ALU: begin
        res.legal = 1'b1;
        // MVN has no Rn, CMP has no Rd
        if (r.op != OP_MVN) res.word[RN_LSB +: 3] = r.rn;
        if (r.op != OP_CMP) res.word[RD_LSB +: 3] = r.rd;
        res.word[SH_LSB +: 2] = r.shift;
        res.word[RM_LSB +: 3] = r.rm;
      end
      OPC_LDR, OPC_STR: begin
        // imm must be representable as a signed 5-bit value
        res.legal             = (r.op == OP_MEM) && (r.imm[7:5] == {3{r.imm[4]}});
        res.word[RN_LSB +: 3] = r.rn;
        res.word[RD_LSB +: 3] = r.rd;
        res.word[4:0]         = r.imm[4:0];
      end
      default: res.legal = 1'b0;
    endcase
    return res;
  endfunction

  enc_req_t       req;
  enc_res_t       res;
  logic           accept;
  logic           fifo_full, fifo_empty;
  logic           err_q, err_d;
  logic [ERRW-1:0] err_count_q, err_count_d;

  assign req = '{opcode: in_opcode, op: in_op, rn: in_rn, rd: in_rd,
                 rm: in_rm, shift: in_shift, imm: in_imm};
  assign res = encode(req);

  assign in_ready  = ~fifo_full;
  assign accept    = in_valid & in_ready;
  assign out_valid = ~fifo_empty;
  assign err       = err_q;
  assign err_count = err_count_q;

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept & res.legal),
    .wdata (res.word),
    .pop   (out_ready),
    .rdata (out_instr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Illegal-request pulse and saturating counter next state
  always_comb begin
    err_d       = accept & ~res.legal;
    err_count_d = err_count_q;
    if (err_d && !(&err_count_q)) err_count_d = err_count_q + 1'b1;
  end

  // Error reporting registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

endmodule
